// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial BCD adder controller.
// Sequences an external single-digit BCD adder over DIGITS digits. The least
// significant digit goes first, and each cycle's carry-out is fed back as the
// next cycle's carry-in.
//
// Optional feature: define BCD_SUB_EN to add the 'sub' port. When sub is high,
// B is nine's-complemented digit by digit and the initial carry is 1, so the
// result is the ten's-complement difference A-B.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           operation request, sampled only in IDLE
//   a_in, b_in      packed BCD operands, least significant digit in [3:0]
//   sub             (BCD_SUB_EN only) subtract request, sampled with start
//   dig_a, dig_b    digit operands to the external adder (zero outside ADD)
//   dig_cin         carry-in to the external adder (zero outside ADD)
//   dig_s, dig_cout combinational sum and carry-out from the external adder
//   sum, cout       registered BCD result and final carry
//   busy            high while the digits are being added
//   done            one-cycle completion pulse
//   err             an operand digit was greater than 9
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic [3:0]          dig_a,
  output logic [3:0]          dig_b,
  output logic                dig_cin,
  input  logic [3:0]          dig_s,
  input  logic                dig_cout,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIGITS-1:0][3:0] a_q;
  logic [DIGITS-1:0][3:0] b_q;
  logic [DIGITS-1:0][3:0] sum_q;
  logic [IW-1:0]          idx_q;
  logic                   carry_q;
  logic                   cout_q;
  logic                   err_q;
  logic                   operands_ok_c;
  logic                   last_c;
  logic [3:0]             b_dig_c;
  logic                   carry_init_c;
`ifdef BCD_SUB_EN
  logic                   sub_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

  // Every digit of both operands must be a legal BCD digit (0..9).
  always_comb begin
    operands_ok_c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((a_in[4*i +: 4] > 4'd9) || (b_in[4*i +: 4] > 4'd9)) begin
        operands_ok_c = 1'b0;
      end
    end
  end

  assign last_c = (idx_q == IW'(DIGITS - 1));

  // B digit as presented to the adder: nine's complement when subtracting.
`ifdef BCD_SUB_EN
  assign b_dig_c      = sub_q ? (4'd9 - b_q[idx_q]) : b_q[idx_q];
  assign carry_init_c = sub;
`else
  assign b_dig_c      = b_q[idx_q];
  assign carry_init_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Invalid operands skip ADD and go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = operands_ok_c ? ADD : DONE;
        end
      end
      ADD: begin
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. dig_* feed the external adder within the same cycle.
  always_comb begin
    dig_a   = 4'd0;
    dig_b   = 4'd0;
    dig_cin = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ADD: begin
        dig_a   = a_q[idx_q];
        dig_b   = b_dig_c;
        dig_cin = carry_q;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, digit index, carry chain and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (operands_ok_c) begin
              a_q     <= a_in;
              b_q     <= b_in;
              idx_q   <= '0;
              carry_q <= carry_init_c;
              err_q   <= 1'b0;
`ifdef BCD_SUB_EN
              sub_q   <= sub;
`endif
            end else begin
              sum_q  <= '0;
              cout_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end
        end
        ADD: begin
          sum_q[idx_q] <= dig_s;
          carry_q      <= dig_cout;
          idx_q        <= idx_q + IW'(1);
          if (last_c) begin
            cout_q <= dig_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl (DIGITS=4). It models the external digit
// adder behaviourally and checks every result against decimal arithmetic.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic [3:0]   dig_a;
  logic [3:0]   dig_b;
  logic         dig_cin;
  logic [3:0]   dig_s;
  logic         dig_cout;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
`ifdef BCD_SUB_EN
    .sub      (sub),
`endif
    .dig_a    (dig_a),
    .dig_b    (dig_b),
    .dig_cin  (dig_cin),
    .dig_s    (dig_s),
    .dig_cout (dig_cout),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Behavioural single-digit BCD adder.
  logic [4:0] dsum;
  assign dsum     = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
  assign dig_cout = (dsum > 5'd9);
  assign dig_s    = dig_cout ? 4'(dsum - 5'd10) : dsum[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // Reference model: plain decimal arithmetic modulo 10^DIGITS.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       output logic [W-1:0] esum, output logic ecout, output logic eerr);
    int modv = 1;
    int t;
    for (int i = 0; i < DIGITS; i++) modv = modv * 10;
    if (!bcd_ok(a) || !bcd_ok(b)) begin
      esum = '0; ecout = 1'b0; eerr = 1'b1;
    end else begin
      if (s) t = bcd2int(a) + (modv - 1 - bcd2int(b)) + 1;
      else   t = bcd2int(a) + bcd2int(b);
      ecout = (t >= modv);
      esum  = int2bcd(t % modv);
      eerr  = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".dig_a"}, 32'(dig_a), 32'd0);
    check({tag, ".dig_b"}, 32'(dig_b), 32'd0);
    check({tag, ".dig_cin"}, 32'(dig_cin), 32'd0);
  endtask

  // One operation. inject > 0 pulses start with fresh operands on that ADD cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input int inject);
    logic [W-1:0] esum;
    logic         ecout;
    logic         eerr;
    int           n;
    int           nbusy;
    model(a, b, s, esum, ecout, eerr);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
`ifdef BCD_SUB_EN
    sub = s;
`endif
    @(negedge clk);
    start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) begin
        nbusy++;
        check({tag, ".dig_a"}, 32'(dig_a), 32'(a[4*(n-1) +: 4]));
        check({tag, ".dig_b"}, 32'(dig_b), s ? 32'(4'd9 - b[4*(n-1) +: 4]) : 32'(b[4*(n-1) +: 4]));
      end
      if (inject > 0 && n == inject) begin
        a_in  = rand_bcd();
        b_in  = rand_bcd();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(n), eerr ? 32'd1 : 32'(DIGITS + 1));
    check({tag, ".busy_cycles"}, 32'(nbusy), eerr ? 32'd0 : 32'(DIGITS));
    check({tag, ".busy_with_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(esum));
    check({tag, ".cout"}, 32'(cout), 32'(ecout));
    check({tag, ".err"}, 32'(err), 32'(eerr));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".sum_hold"}, 32'(sum), 32'(esum));
    check({tag, ".err_hold"}, 32'(err), 32'(eerr));
    check_idle_outputs(tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int saw_done;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    #1;
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.err", 32'(err), 32'd0);
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("basic", 16'h1234, 16'h5678, 1'b0, 0);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 0);
    run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 0);
    run_op("invalid_b", 16'h1111, 16'hF000, 1'b0, 0);
    run_op("restart_ignored", 16'h4321, 16'h1289, 1'b0, 2);
    run_op("zero", 16'h0000, 16'h0000, 1'b0, 0);

    // Reset on the 3rd ADD cycle aborts the operation without a done pulse.
    @(negedge clk);
    a_in  = 16'h8888;
    b_in  = 16'h7777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.err", 32'(err), 32'd0);
    check_idle_outputs("abort");
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort.no_done", 32'(saw_done), 32'd0);
    run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 0);

`ifdef BCD_SUB_EN
    run_op("sub_pos", 16'h5000, 16'h1234, 1'b1, 0);
    run_op("sub_neg", 16'h1234, 16'h5000, 1'b1, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(9) == 0) ra[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
      if ($urandom_range(9) == 0) rb[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
`ifdef BCD_SUB_EN
      run_op("rand", ra, rb, 1'($urandom_range(1)), ($urandom_range(3) == 0) ? 3 : 0);
`else
      run_op("rand", ra, rb, 1'b0, ($urandom_range(3) == 0) ? 3 : 0);
`endif
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of BCD digits per operand (legal range 1..8).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a_in  input  4*DIGITS  operand A, packed BCD, least-significant digit in [3:0].
REQ-006 b_in  input  4*DIGITS  operand B, packed BCD, same packing as a_in.
REQ-007 dig_a, dig_b  output  4 each  digit operands driven to the external single-digit BCD adder.
REQ-008 dig_cin  output  1  carry-in to the digit adder.
REQ-009 dig_s  input  4  digit-adder sum; valid combinationally in the same cycle.
REQ-010 dig_cout  input  1  digit-adder carry-out; valid combinationally in the same cycle.
REQ-011 sum  output  4*DIGITS  registered BCD result.
REQ-012 cout  output  1  registered final decimal carry.
REQ-013 busy  output  1  high while in ADD.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  invalid-operand flag.

Function
REQ-016 The FSM SHALL have states IDLE, ADD and DONE; reset state is IDLE.
REQ-017 IDLE, start=1, all operand digits <=9: latch a_in/b_in, clear the carry register, set the digit index to 0, clear err, go to ADD.
REQ-018 IDLE, start=1, any digit of a_in or b_in >9: set err=1, sum=0, cout=0, go directly to DONE; no ADD cycles occur.
REQ-019 ADD drives dig_a/dig_b from latched digit[index] and dig_cin from the carry register.
- Each ADD cycle writes dig_s into sum digit[index] and dig_cout into the carry register, then increments the index.
REQ-020 ADD after index DIGITS-1: copy dig_cout into cout, go to DONE.
REQ-021 DONE asserts done=1 for exactly one cycle, then returns to IDLE.
- Latency for a valid start: done high DIGITS+1 cycles after the sampling edge; error path: 1 cycle.
REQ-022 sum, cout and err SHALL hold their values from DONE until the next accepted start.
- Digits of sum not yet written during ADD hold their previous values.
REQ-023 start is ignored in ADD and DONE; no queuing; a_in/b_in changes after acceptance have no effect.
REQ-024 Outside ADD, dig_a=0, dig_b=0 and dig_cin=0.
REQ-025 busy=1 exactly in ADD; done and busy are never high together.

Reset
REQ-026 rst=1 SHALL immediately force:
- state IDLE, index 0, carry register 0;
- sum=0, cout=0, busy=0, done=0, err=0;
- dig_a=0, dig_b=0, dig_cin=0.
REQ-027 Reset during ADD SHALL abort the operation with no done pulse; the first start after rst falls is handled normally.

Configuration
REQ-028 Macro BCD_SUB_EN: when defined, an input port sub (1 bit) is added and sampled with start.
- sub=1: each B digit is presented as 9 minus the digit, and the carry register is initialised to 1 (ten's complement).
- In sub=1 mode, cout=1 means A>=B, and sum is A-B.
- cout=0 means a borrow, and sum is the ten's complement of B-A.
REQ-029 BCD_SUB_EN undefined: no sub port, the initial carry is always 0, add only.

Verification (DIGITS=4, bench connects a behavioural BCD digit adder)
REQ-030 a_in=0x1234, b_in=0x5678, start pulse -> busy for 4 cycles; done on cycle 5; sum=0x6912, cout=0.
REQ-031 a_in=0x9999, b_in=0x0001 -> sum=0x0000, cout=1; carry ripples through all digits.
REQ-032 a_in=0x00A0, b_in=0x0000 -> err=1, sum=0, cout=0, done 1 cycle after start, busy never high.
REQ-033 Start pulsed again on the 2nd ADD cycle with different operands -> ignored; the first result is unchanged.
REQ-034 rst asserted on the 3rd ADD cycle -> all outputs 0 immediately, no done.
- Next start with 0x0005+0x0005 -> sum=0x0010, cout=0.
REQ-035 (BCD_SUB_EN) 5000-1234 -> sum=0x3766, cout=1; 1234-5000 -> sum=0x6234, cout=0.
